// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-key debounce, rise strobe and key code.
// Optional debounce is compiled in when KYPD_DEBOUNCE_EN is defined; otherwise keys follow the raw sample.
module keypad_scanner #(
   parameter int SCAN_TICKS     = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] keyout,
   output logic        key_strobe,
   output logic [3:0]  key_code
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [1:0]    c;
   logic [TW-1:0] tick;
   logic          sample_pt;
   logic [3:0]    samp;
   logic [15:0]   nxt_key;
   logic [15:0]   rise;
   logic [3:0]    rise_code;

   assign col       = ~(4'b0001 << c);
   assign sample_pt = (tick == TICK_LAST);
   assign samp      = ~row_sync;
   assign rise      = nxt_key & ~keyout;

`ifdef KYPD_DEBOUNCE_EN
   localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

   logic [3:0] cnt     [16];
   logic [3:0] nxt_cnt [16];

   // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      nxt_key = keyout;
      nxt_cnt = cnt;
      for (int r = 0; r < 4; r++) begin
         logic [3:0] k;
         k = {c, 2'(r)};
         if (samp[r] == keyout[k]) begin
            nxt_cnt[k] = '0;
         end else if (cnt[k] == CNT_LAST) begin
            nxt_key[k] = samp[r];
            nxt_cnt[k] = '0;
         end else begin
            nxt_cnt[k] = cnt[k] + 4'd1;
         end
      end
   end
`else
   always_comb begin
      nxt_key = keyout;
      for (int r = 0; r < 4; r++) begin
         nxt_key[{c, 2'(r)}] = samp[r];
      end
   end
`endif

   // Downward scan leaves the lowest rising index as the reported code.
   always_comb begin
      rise_code = '0;
      for (int i = 15; i >= 0; i--) begin
         if (rise[i]) rise_code = 4'(i);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         row_meta   <= 4'b1111;
         row_sync   <= 4'b1111;
         c          <= '0;
         tick       <= '0;
         keyout     <= '0;
         key_strobe <= 1'b0;
         key_code   <= '0;
`ifdef KYPD_DEBOUNCE_EN
         // NOTE: the counter array is small state, not RAM, so it is cleared so a reset drops partial counts.
         for (int i = 0; i < 16; i++) cnt[i] <= '0;
`endif
      end else begin
         row_meta   <= row;
         row_sync   <= row_meta;
         key_strobe <= 1'b0;
         if (sample_pt) begin
            tick   <= '0;
            c      <= c + 2'd1;
            keyout <= nxt_key;
`ifdef KYPD_DEBOUNCE_EN
            cnt    <= nxt_cnt;
`endif
            if (|rise) begin
               key_strobe <= 1'b1;
               key_code   <= rise_code;
            end
         end else begin
            tick <= tick + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected key events are queued with the edge they must land on.
// Expectations follow KYPD_DEBOUNCE_EN the same way the design build does.
module tb_keypad_scanner;

   localparam int ST = 8;
`ifdef KYPD_DEBOUNCE_EN
   localparam bit DBN = 1'b1;
`else
   localparam bit DBN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [15:0] keys;
      logic        strobe;
      logic [3:0]  code;
   } evt_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] keyout;
   logic        key_strobe;
   logic [3:0]  key_code;

   logic [15:0] pressed = '0;
   logic [15:0] prev_keys = '0;
   bit          mon_en = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   evt_t        exp_q[$];

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(3)) dut (
      .clk        (clk),
      .clr        (clr),
      .row        (row),
      .col        (col),
      .keyout     (keyout),
      .key_strobe (key_strobe),
      .key_code   (key_code)
   );

   always #10 clk = ~clk;

   // Keypad model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'b1111;
      for (int cc = 0; cc < 4; cc++)
         for (int r = 0; r < 4; r++)
            if (!col[cc] && pressed[4*cc+r]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int samp_edge(input int scan, input int column);
      return ST * (4 * scan + column + 1);
   endfunction

   task automatic push(input int cy, input logic [15:0] k, input logic s, input logic [3:0] code);
      evt_t e;
      e.cyc = cy; e.keys = k; e.strobe = s; e.code = code;
      exp_q.push_back(e);
   endtask

   // Monitor: any keyout change or strobe must match the next queued event.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         cyc++;
         if (keyout !== prev_keys || key_strobe !== 1'b0) begin
            if (exp_q.size() == 0) begin
               check("unexp_keyout", keyout, prev_keys);
               check("unexp_strobe", key_strobe, 1'b0);
            end else begin
               evt_t e;
               e = exp_q.pop_front();
               check("evt_cyc", cyc, e.cyc);
               check("evt_keyout", keyout, e.keys);
               check("evt_strobe", key_strobe, e.strobe);
               check("evt_code", key_code, e.code);
            end
            prev_keys = keyout;
         end
      end
   end

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 5000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (cyc < n) check("wait_timeout", cyc, n);
   endtask

   task automatic do_reset(input string tag);
      check({tag, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      mon_en  = 1'b0;
      pressed = '0;
      clr     = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_rst_col"}, col, 4'b1110);
      check({tag, "_rst_keyout"}, keyout, 16'h0000);
      check({tag, "_rst_strobe"}, key_strobe, 1'b0);
      check({tag, "_rst_code"}, key_code, 4'h0);
      clr       = 1'b0;
      cyc       = 0;
      prev_keys = '0;
      mon_en    = 1'b1;
   endtask

   initial begin
      // Column stepping after reset.
      do_reset("scan");
      wait_cyc(7);  check("col_c7", col, 4'b1110);
      wait_cyc(8);  check("col_c8", col, 4'b1101);
      wait_cyc(16); check("col_c16", col, 4'b1011);
      wait_cyc(24); check("col_c24", col, 4'b0111);
      wait_cyc(32); check("col_c32", col, 4'b1110);
      wait_cyc(40);

      // Key 5 held from the start.
      do_reset("key5");
      pressed = 16'h0020;
      push(DBN ? samp_edge(2, 1) : samp_edge(0, 1), 16'h0020, 1'b1, 4'd5);
      wait_cyc(130);

      // Key 5 bounce: pressed 2 scans, released 1, pressed again.
      do_reset("bounce");
      pressed = 16'h0020;
      if (DBN) begin
         push(samp_edge(5, 1), 16'h0020, 1'b1, 4'd5);
      end else begin
         push(samp_edge(0, 1), 16'h0020, 1'b1, 4'd5);
         push(samp_edge(2, 1), 16'h0000, 1'b0, 4'd5);
         push(samp_edge(3, 1), 16'h0020, 1'b1, 4'd5);
      end
      wait_cyc(68);  pressed = 16'h0000;
      wait_cyc(100); pressed = 16'h0020;
      wait_cyc(200);

      // Keys 8 and 10 together, then released.
      do_reset("dual");
      pressed = 16'h0500;
      if (DBN) begin
         push(samp_edge(2, 2), 16'h0500, 1'b1, 4'd8);
         push(samp_edge(5, 2), 16'h0000, 1'b0, 4'd8);
      end else begin
         push(samp_edge(0, 2), 16'h0500, 1'b1, 4'd8);
         push(samp_edge(3, 2), 16'h0000, 1'b0, 4'd8);
      end
      wait_cyc(100); pressed = 16'h0000;
      wait_cyc(200);

      // Key 0 interrupted by clr after two pressed samples.
      do_reset("midclr");
      pressed = 16'h0001;
      if (!DBN) push(samp_edge(0, 0), 16'h0001, 1'b1, 4'd0);
      wait_cyc(50);
      check("midclr_keyout_pre", keyout, DBN ? 16'h0000 : 16'h0001);
      do_reset("midclr2");
      pressed = 16'h0001;
      push(DBN ? samp_edge(2, 0) : samp_edge(0, 0), 16'h0001, 1'b1, 4'd0);
      if (DBN) begin
         wait_cyc(samp_edge(1, 0) + 2);
         check("midclr_keyout_mid", keyout, 16'h0000);
      end
      wait_cyc(90);

      // Key 15 press and release.
      do_reset("key15");
      pressed = 16'h8000;
      if (DBN) begin
         push(samp_edge(2, 3), 16'h8000, 1'b1, 4'd15);
         push(samp_edge(5, 3), 16'h0000, 1'b0, 4'd15);
         wait_cyc(100);
      end else begin
         push(samp_edge(0, 3), 16'h8000, 1'b1, 4'd15);
         push(samp_edge(1, 3), 16'h0000, 1'b0, 4'd15);
         wait_cyc(40);
      end
      pressed = 16'h0000;
      wait_cyc(210);

      check("final_pending", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
